// File: rtl/vend_pkg.sv
// Shared vending-machine types: state encoding, price table, coin values.
package vend_pkg;

    localparam int unsigned PAID_W  = 8;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned QTY_W   = 2;
    localparam int unsigned PRICE_W = 3;
    localparam int unsigned COST_W  = 5;

    localparam logic [PRICE_W-1:0] PRICE_T0 = 3'd2;
    localparam logic [PRICE_W-1:0] PRICE_T1 = 3'd3;
    localparam logic [PRICE_W-1:0] PRICE_T2 = 3'd4;
    localparam logic [PRICE_W-1:0] PRICE_T3 = 3'd5;

    localparam logic [PAID_W-1:0] COIN_10 = 8'd10;
    localparam logic [PAID_W-1:0] COIN_5  = 8'd5;
    localparam logic [PAID_W-1:0] COIN_1  = 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_TICKET = 3'd2,
        ST_CHANGE = 3'd3,
        ST_CLEAR  = 3'd4
    } vend_state_t;

    // Request snapshot taken when the customer confirms or cancels.
    typedef struct packed {
        logic [PAID_W-1:0] paid;
        logic [TYPE_W-1:0] sel_type;
        logic [QTY_W-1:0]  sel_qty;
    } sale_req_t;

    // Total price for a ticket type and quantity; at most 5*3 = 15.
    function automatic logic [COST_W-1:0] ticket_cost(input logic [TYPE_W-1:0] sel_type,
                                                      input logic [QTY_W-1:0]  sel_qty);
        logic [PRICE_W-1:0] price;
        case (sel_type)
            2'd0:    price = PRICE_T0;
            2'd1:    price = PRICE_T1;
            2'd2:    price = PRICE_T2;
            default: price = PRICE_T3;
        endcase
        return COST_W'(price) * COST_W'(sel_qty);
    endfunction

endpackage

// File: rtl/ticket_dispense_ctrl_if.sv
// Coin-counter / dispenser side signals of the sale controller.
interface ticket_dispense_ctrl_if;
    import vend_pkg::*;

    logic [PAID_W-1:0] paid;
    logic [TYPE_W-1:0] sel_type;
    logic [QTY_W-1:0]  sel_qty;
    logic              confirm;
    logic              cancel;
    logic              tkt_pulse;
    logic              chg_10;
    logic              chg_5;
    logic              chg_1;
    logic              cnt_clr;
    logic              coin_lock;
    logic              reject;
    logic              busy;

    modport master (
        output paid, sel_type, sel_qty, confirm, cancel,
        input  tkt_pulse, chg_10, chg_5, chg_1, cnt_clr, coin_lock, reject, busy
    );

    modport slave (
        input  paid, sel_type, sel_qty, confirm, cancel,
        output tkt_pulse, chg_10, chg_5, chg_1, cnt_clr, coin_lock, reject, busy
    );

endinterface

// File: rtl/ticket_dispense_ctrl_pulse_pacer.sv
// Slot timer: start marks slot zero, then slot is high every PULSE_GAP cycles.
// slot is high in the cycle whose decision becomes visible on the next edge.
module pulse_pacer #(
    parameter int unsigned PULSE_GAP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic slot
);

    localparam int unsigned CNT_W = (PULSE_GAP > 2) ? $clog2(PULSE_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(PULSE_GAP - 1);

    logic [CNT_W-1:0] cnt;

    // Down-counter restarted by start; slot fires as it wraps through zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            slot <= 1'b0;
        end else if (start) begin
            cnt  <= CNT_TOP;
            slot <= 1'b0;
        end else begin
            cnt  <= (cnt == '0) ? CNT_TOP : cnt - CNT_W'(1);
            slot <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/ticket_dispense_ctrl.sv
// Sale controller: price check, paced ticket pulses, greedy change, counter clear.
module ticket_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_GAP = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    ticket_dispense_ctrl_if.slave bus
);

    vend_state_t       state;
    vend_state_t       state_nxt;
    sale_req_t         req;
    sale_req_t         req_nxt;
    logic [QTY_W-1:0]  tickets_left;
    logic [QTY_W-1:0]  tickets_nxt;
    logic [PAID_W-1:0] change;
    logic [PAID_W-1:0] change_nxt;
    logic [COST_W-1:0] cost;
    logic              sale_ok;
    logic              pacer_start;
    logic              slot;

    logic tkt_d, c10_d, c5_d, c1_d, clr_d, rej_d, busy_d;
    logic tkt_q, c10_q, c5_q, c1_q, clr_q, rej_q, busy_q;

    assign cost    = ticket_cost(req.sel_type, req.sel_qty);
    assign sale_ok = (req.sel_qty != '0) && (req.paid >= PAID_W'(cost));

    pulse_pacer #(.PULSE_GAP(PULSE_GAP)) u_pacer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (pacer_start),
        .slot  (slot)
    );

    // State and sale datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            req          <= '0;
            tickets_left <= '0;
            change       <= '0;
        end else begin
            state        <= state_nxt;
            req          <= req_nxt;
            tickets_left <= tickets_nxt;
            change       <= change_nxt;
        end
    end

    // Next state and datapath updates; the first ticket is issued straight from CHECK.
    always_comb begin
        state_nxt   = state;
        req_nxt     = req;
        tickets_nxt = tickets_left;
        change_nxt  = change;
        pacer_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cancel) begin
                    req_nxt.paid = bus.paid;
                    tickets_nxt  = '0;
                    change_nxt   = bus.paid;
                    pacer_start  = 1'b1;
                    state_nxt    = ST_CHANGE;
                end else if (bus.confirm) begin
                    req_nxt.paid     = bus.paid;
                    req_nxt.sel_type = bus.sel_type;
                    req_nxt.sel_qty  = bus.sel_qty;
                    state_nxt        = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!sale_ok) begin
                    state_nxt = ST_IDLE;
                end else begin
                    change_nxt  = req.paid - PAID_W'(cost);
                    tickets_nxt = req.sel_qty - QTY_W'(1);
                    pacer_start = 1'b1;
                    state_nxt   = (req.sel_qty == QTY_W'(1)) ? ST_CHANGE : ST_TICKET;
                end
            end
            ST_TICKET: begin
                if (slot) begin
                    tickets_nxt = tickets_left - QTY_W'(1);
                    if (tickets_left == QTY_W'(1)) begin
                        state_nxt = ST_CHANGE;
                    end
                end
            end
            ST_CHANGE: begin
                if (slot) begin
                    if (change >= COIN_10) begin
                        change_nxt = change - COIN_10;
                    end else if (change >= COIN_5) begin
                        change_nxt = change - COIN_5;
                    end else if (change != '0) begin
                        change_nxt = change - COIN_1;
                    end else begin
                        state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered pulse and status outputs.
    always_comb begin
        tkt_d  = 1'b0;
        c10_d  = 1'b0;
        c5_d   = 1'b0;
        c1_d   = 1'b0;
        clr_d  = 1'b0;
        rej_d  = 1'b0;
        busy_d = (state_nxt != ST_IDLE) && (state_nxt != ST_CLEAR);
        case (state)
            ST_CHECK: begin
                if (sale_ok) begin
                    tkt_d = 1'b1;
                end else begin
                    rej_d = 1'b1;
                end
            end
            ST_TICKET: tkt_d = slot;
            ST_CHANGE: begin
                if (slot) begin
                    if (change >= COIN_10) begin
                        c10_d = 1'b1;
                    end else if (change >= COIN_5) begin
                        c5_d = 1'b1;
                    end else if (change != '0) begin
                        c1_d = 1'b1;
                    end else begin
                        clr_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tkt_q  <= 1'b0;
            c10_q  <= 1'b0;
            c5_q   <= 1'b0;
            c1_q   <= 1'b0;
            clr_q  <= 1'b0;
            rej_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            tkt_q  <= tkt_d;
            c10_q  <= c10_d;
            c5_q   <= c5_d;
            c1_q   <= c1_d;
            clr_q  <= clr_d;
            rej_q  <= rej_d;
            busy_q <= busy_d;
        end
    end

    assign bus.tkt_pulse = tkt_q;
    assign bus.chg_10    = c10_q;
    assign bus.chg_5     = c5_q;
    assign bus.chg_1     = c1_q;
    assign bus.cnt_clr   = clr_q;
    assign bus.reject    = rej_q;
    assign bus.busy      = busy_q;
    assign bus.coin_lock = busy_q;

endmodule

// File: tb/tb_ticket_dispense_ctrl.sv
// Bench for ticket_dispense_ctrl: per-cycle event trace against an event-list model.
module tb_ticket_dispense_ctrl;

    localparam int GAP  = 4;
    localparam int MAXK = 160;

    localparam int E_NONE  = 0;
    localparam int E_TKT   = 1;
    localparam int E_C10   = 2;
    localparam int E_C5    = 3;
    localparam int E_C1    = 4;
    localparam int E_CLR   = 5;
    localparam int E_REJ   = 6;
    localparam int E_MULTI = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ticket_dispense_ctrl_if bus ();

    ticket_dispense_ctrl #(.PULSE_GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int exp_code [MAXK];
    int exp_busy [MAXK];
    int obs_code [MAXK];
    int obs_busy [MAXK];
    int obs_lock [MAXK];
    int exp_end;
    int exp_len;

    // Expected event per cycle k after the request edge, from the sale rules.
    task automatic build_model(input int paid, input int ty, input int qty, input bit is_cancel);
        int evs[$];
        int first, change, tickets, cost;
        for (int k = 0; k < MAXK; k++) begin
            exp_code[k] = E_NONE;
            exp_busy[k] = 0;
        end
        cost = (ty + 2) * qty;
        if (is_cancel) begin
            tickets = 0;
            change  = paid;
            first   = GAP;
        end else if (qty == 0 || paid < cost) begin
            exp_code[1] = E_REJ;
            exp_busy[0] = 1;
            exp_end     = 1;
            exp_len     = 4;
            return;
        end else begin
            tickets = qty;
            change  = paid - cost;
            first   = 1;
        end
        repeat (tickets)              evs.push_back(E_TKT);
        repeat (change / 10)          evs.push_back(E_C10);
        repeat ((change % 10) / 5)    evs.push_back(E_C5);
        repeat (change % 5)           evs.push_back(E_C1);
        for (int i = 0; i < evs.size(); i++) exp_code[first + i * GAP] = evs[i];
        exp_end = first + evs.size() * GAP;
        exp_code[exp_end] = E_CLR;
        for (int k = 0; k < exp_end; k++) exp_busy[k] = 1;
        exp_len = exp_end + 3;
    endtask

    function automatic int code_of();
        int n;
        n = int'(bus.tkt_pulse) + int'(bus.chg_10) + int'(bus.chg_5) + int'(bus.chg_1)
          + int'(bus.cnt_clr) + int'(bus.reject);
        if (n == 0) return E_NONE;
        if (n > 1)  return E_MULTI;
        if (bus.tkt_pulse) return E_TKT;
        if (bus.chg_10)    return E_C10;
        if (bus.chg_5)     return E_C5;
        if (bus.chg_1)     return E_C1;
        if (bus.cnt_clr)   return E_CLR;
        return E_REJ;
    endfunction

    // Drive one request and record len cycles of outputs; optional mid-run noise and reset.
    task automatic run_txn(input int paid, input int ty, input int qty, input bit conf,
                           input bit canc, input bit noise, input int len, input int rst_k);
        @(posedge clk); #1;
        bus.paid     = 8'(paid);
        bus.sel_type = 2'(ty);
        bus.sel_qty  = 2'(qty);
        bus.confirm  = conf;
        bus.cancel   = canc;
        @(posedge clk); #1;
        bus.confirm = 1'b0;
        bus.cancel  = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            obs_code[k] = code_of();
            obs_busy[k] = int'(bus.busy);
            obs_lock[k] = int'(bus.coin_lock);
            bus.confirm = 1'b0;
            bus.cancel  = 1'b0;
            rst_n       = 1'b1;
            if (noise && k < exp_end) begin
                bus.confirm = 1'($urandom);
                bus.cancel  = 1'($urandom);
                bus.paid    = 8'($urandom);
            end
            if (k == rst_k) rst_n = 1'b0;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.paid = '0; bus.sel_type = '0; bus.sel_qty = '0;
        bus.confirm = 1'b0; bus.cancel = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (code_of() !== E_NONE || bus.busy !== 1'b0 || bus.coin_lock !== 1'b0) begin
                n_err++;
                $display("FAIL reset k=%0d event got %0d busy %b lock %b want all 0",
                         k, code_of(), bus.busy, bus.coin_lock);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_purchase();
        int ty, qty, paid;
        for (int t = 0; t < 10; t++) begin
            if (t == 0) begin ty = 1; qty = 2; paid = 20; end
            else if (t == 1) begin ty = 3; qty = 3; paid = 15; end
            else begin
                ty   = int'($urandom_range(0, 3));
                qty  = int'($urandom_range(1, 3));
                paid = (ty + 2) * qty + int'($urandom_range(0, 30));
            end
            build_model(paid, ty, qty, 1'b0);
            run_txn(paid, ty, qty, 1'b1, 1'b0, t > 1, exp_len, -1);
            for (int k = 0; k < exp_len; k++) begin
                n_vec++;
                if (obs_code[k] !== exp_code[k]) begin
                    n_err++;
                    $display("FAIL purchase t=%0d k=%0d event got %0d want %0d", t, k, obs_code[k], exp_code[k]);
                end
                n_vec++;
                if (obs_busy[k] !== exp_busy[k] || obs_lock[k] !== exp_busy[k]) begin
                    n_err++;
                    $display("FAIL purchase_busy t=%0d k=%0d busy %0d lock %0d want %0d",
                             t, k, obs_busy[k], obs_lock[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_reject();
        int ty, qty, paid;
        for (int t = 0; t < 6; t++) begin
            if (t == 0) begin ty = 2; qty = 2; paid = 7; end
            else if (t == 1) begin ty = int'($urandom_range(0, 3)); qty = 0; paid = 50; end
            else begin
                ty   = int'($urandom_range(0, 3));
                qty  = int'($urandom_range(1, 3));
                paid = int'($urandom_range(0, (ty + 2) * qty - 1));
            end
            build_model(paid, ty, qty, 1'b0);
            run_txn(paid, ty, qty, 1'b1, 1'b0, 1'b1, exp_len, -1);
            for (int k = 0; k < exp_len; k++) begin
                n_vec++;
                if (obs_code[k] !== exp_code[k]) begin
                    n_err++;
                    $display("FAIL reject t=%0d k=%0d event got %0d want %0d", t, k, obs_code[k], exp_code[k]);
                end
                n_vec++;
                if (obs_busy[k] !== exp_busy[k] || obs_lock[k] !== exp_busy[k]) begin
                    n_err++;
                    $display("FAIL reject_busy t=%0d k=%0d busy %0d lock %0d want %0d",
                             t, k, obs_busy[k], obs_lock[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_cancel();
        int paid;
        bit conf;
        for (int t = 0; t < 6; t++) begin
            conf = 1'b0;
            if (t == 0) paid = 255;
            else if (t == 1) begin paid = 16; conf = 1'b1; end
            else if (t == 2) paid = 0;
            else begin paid = int'($urandom_range(1, 80)); conf = 1'($urandom); end
            build_model(paid, 0, 1, 1'b1);
            run_txn(paid, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), conf, 1'b1,
                    1'b1, exp_len, -1);
            for (int k = 0; k < exp_len; k++) begin
                n_vec++;
                if (obs_code[k] !== exp_code[k]) begin
                    n_err++;
                    $display("FAIL cancel t=%0d k=%0d event got %0d want %0d", t, k, obs_code[k], exp_code[k]);
                end
                n_vec++;
                if (obs_busy[k] !== exp_busy[k] || obs_lock[k] !== exp_busy[k]) begin
                    n_err++;
                    $display("FAIL cancel_busy t=%0d k=%0d busy %0d lock %0d want %0d",
                             t, k, obs_busy[k], obs_lock[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int rst_k;
        for (int pass = 0; pass < 2; pass++) begin
            build_model(20, 1, 2, 1'b0);
            rst_k = -1;
            if (pass == 0) begin
                // Events: tkt, tkt, c10, c1, c1 -> second chg_1 is event index 4.
                rst_k = 1 + 4 * GAP;
                for (int k = rst_k + 1; k < MAXK; k++) begin
                    exp_code[k] = E_NONE;
                    exp_busy[k] = 0;
                end
                exp_len = rst_k + 3 * GAP;
            end
            run_txn(20, 1, 2, 1'b1, 1'b0, 1'b0, exp_len, rst_k);
            for (int k = 0; k < exp_len; k++) begin
                n_vec++;
                if (obs_code[k] !== exp_code[k]) begin
                    n_err++;
                    $display("FAIL reset_mid p=%0d k=%0d event got %0d want %0d", pass, k, obs_code[k], exp_code[k]);
                end
                n_vec++;
                if (obs_busy[k] !== exp_busy[k] || obs_lock[k] !== exp_busy[k]) begin
                    n_err++;
                    $display("FAIL reset_mid_busy p=%0d k=%0d busy %0d lock %0d want %0d",
                             pass, k, obs_busy[k], obs_lock[k], exp_busy[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ty, qty, paid;
        bit canc;
        for (int t = 0; t < 10; t++) begin
            canc = ($urandom_range(0, 3) == 0);
            ty   = int'($urandom_range(0, 3));
            qty  = int'($urandom_range(0, 3));
            paid = int'($urandom_range(0, 40));
            build_model(paid, ty, qty, canc);
            run_txn(paid, ty, qty, 1'b1, canc, 1'b1, exp_end + 1, -1);
            for (int k = 0; k <= exp_end; k++) begin
                n_vec++;
                if (obs_code[k] !== exp_code[k]) begin
                    n_err++;
                    $display("FAIL back_to_back t=%0d k=%0d event got %0d want %0d", t, k, obs_code[k], exp_code[k]);
                end
                n_vec++;
                if (obs_busy[k] !== exp_busy[k] || obs_lock[k] !== exp_busy[k]) begin
                    n_err++;
                    $display("FAIL back_to_back_busy t=%0d k=%0d busy %0d lock %0d want %0d",
                             t, k, obs_busy[k], obs_lock[k], exp_busy[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_reject();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

endmodule
